// File: rtl/tt_operand_loader.sv
// Byte-stream to operand-word loader: packs BYTES_IN bytes (lowest first) into one word and
// hands it downstream over valid/ready. Optional short-frame zero padding via TT_LOADER_ZEROPAD_EN.
module tt_operand_loader #(
  parameter int LOG2_BYTES_IN = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [8*(1<<LOG2_BYTES_IN)-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LOG2_BYTES_IN-1:0]     fill_level,
  output logic [7:0]                   word_count
);

  localparam int BYTES_IN = 1 << LOG2_BYTES_IN;
  localparam int WORD_W   = 8 * BYTES_IN;
  localparam logic [LOG2_BYTES_IN-1:0] IDX_LAST = '1;

  logic [WORD_W-1:0]        r_collect;
  logic [LOG2_BYTES_IN-1:0] r_idx;
  logic                     r_pend;
  logic [WORD_W-1:0]        r_out_data;
  logic                     r_out_valid;
  logic [7:0]               r_word_count;

  logic w_accept;
  logic w_xfer;
  logic w_frame_end;

  assign w_accept = in_valid && !r_pend;
  // Collect buffer moves to the output register whenever that register is empty or emptying.
  assign w_xfer   = r_pend && (!r_out_valid || out_ready);

`ifdef TT_LOADER_ZEROPAD_EN
  assign w_frame_end = (r_idx == IDX_LAST) || in_last;
`else
  logic w_unused_last;
  assign w_unused_last = in_last;
  assign w_frame_end   = (r_idx == IDX_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_collect    <= '0;
      r_idx        <= '0;
      r_pend       <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_word_count <= 8'd0;
    end else begin
      if (w_accept) begin
        r_collect[{r_idx, 3'b000} +: 8] <= in_data;
        if (w_frame_end) begin
          r_pend <= 1'b1;
          r_idx  <= '0;
        end else begin
          r_idx  <= r_idx + 1'b1;
        end
      end

      if (w_xfer) begin
        // Clearing here is what leaves untouched slots of a short frame at zero.
        r_out_data   <= r_collect;
        r_out_valid  <= 1'b1;
        r_pend       <= 1'b0;
        r_collect    <= '0;
        r_word_count <= r_word_count + 8'd1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign in_ready   = !r_pend;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign fill_level = r_idx;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_tt_operand_loader.sv
// Directed self-checking bench for tt_operand_loader with LOG2_BYTES_IN=3.
module tb_tt_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fill_level;
  logic [7:0]  word_count;

  int n_cmp = 0;
  int n_bad = 0;

  tt_operand_loader #(.LOG2_BYTES_IN(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until the loader takes it (bounded wait).
  task automatic send_byte(input logic [7:0] d, input logic last);
    bit done;
    done     = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    for (int c = 0; c < 64 && !done; c++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    if (!done) check_eq("accept_timeout", {63'd0, done}, 64'd1);
    in_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    do_reset();

    // Reset state
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_fill", {61'd0, fill_level}, 64'd0);
    check_eq("rst_wcount", {56'd0, word_count}, 64'd0);

    // Full frame streamed with out_ready high
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check_eq("t1_pend_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("t1_vld_at_N", {63'd0, out_valid}, 64'd0);
    check_eq("t1_fill", {61'd0, fill_level}, 64'd0);
    tick();
    check_eq("t1_vld_at_N1", {63'd0, out_valid}, 64'd1);
    check_eq("t1_data", out_data, 64'h0807060504030201);
    check_eq("t1_wcount", {56'd0, word_count}, 64'd1);
    check_eq("t1_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check_eq("t1_drain", {63'd0, out_valid}, 64'd0);
    check_eq("t1_data_kept", out_data, 64'h0807060504030201);

    // Backpressure: two words, one held and one pending
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0);
    in_valid = 1'b0;
    check_eq("t2_in_ready_blocked", {63'd0, in_ready}, 64'd0);
    check_eq("t2_held_data", out_data, 64'h1716151413121110);
    check_eq("t2_held_vld", {63'd0, out_valid}, 64'd1);
    check_eq("t2_wcount", {56'd0, word_count}, 64'd2);
    tick(); tick(); tick();
    check_eq("t2_held_stable", out_data, 64'h1716151413121110);
    check_eq("t2_still_blocked", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    tick();
    check_eq("t2_b2b_vld", {63'd0, out_valid}, 64'd1);
    check_eq("t2_second_data", out_data, 64'h1F1E1D1C1B1A1918);
    check_eq("t2_wcount2", {56'd0, word_count}, 64'd3);
    check_eq("t2_in_ready_back", {63'd0, in_ready}, 64'd1);
    tick();
    check_eq("t2_drained", {63'd0, out_valid}, 64'd0);

    // Source stall mid-frame
    for (int i = 1; i <= 3; i++) send_byte(8'(8'h30 + i), 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("t3_fill_hold", {61'd0, fill_level}, 64'd3);
    check_eq("t3_no_vld", {63'd0, out_valid}, 64'd0);
    for (int i = 4; i <= 8; i++) send_byte(8'(8'h30 + i), 1'b0);
    in_valid = 1'b0;
    tick();
    check_eq("t3_vld", {63'd0, out_valid}, 64'd1);
    check_eq("t3_data", out_data, 64'h3837363534333231);
    check_eq("t3_wcount", {56'd0, word_count}, 64'd4);
    tick();

    // Reset mid-frame discards partial word
    for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i), 1'b0);
    do_reset();
    check_eq("t4_fill_rst", {61'd0, fill_level}, 64'd0);
    check_eq("t4_wcount_rst", {56'd0, word_count}, 64'd0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), 1'b0);
    in_valid = 1'b0;
    tick();
    check_eq("t4_vld", {63'd0, out_valid}, 64'd1);
    check_eq("t4_data", out_data, 64'hA7A6A5A4A3A2A1A0);
    check_eq("t4_wcount", {56'd0, word_count}, 64'd1);
    tick();

    // Short frame with in_last
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    in_valid = 1'b0;
    tick();
`ifdef TT_LOADER_ZEROPAD_EN
    check_eq("t5_zp_vld", {63'd0, out_valid}, 64'd1);
    check_eq("t5_zp_data", out_data, 64'h0000000000CCBBAA);
    check_eq("t5_zp_fill", {61'd0, fill_level}, 64'd0);
`else
    check_eq("t5_nozp_vld", {63'd0, out_valid}, 64'd0);
    check_eq("t5_nozp_fill", {61'd0, fill_level}, 64'd3);
    check_eq("t5_nozp_in_ready", {63'd0, in_ready}, 64'd1);
`endif
    do_reset();

    // word_count wrap: 256 words -> 0, 257th -> 1
    for (int w = 0; w < 256; w++) begin
      for (int b = 0; b < 8; b++) send_byte(8'(w + b), 1'b0);
    end
    in_valid = 1'b0;
    tick();
    check_eq("t6_wrap_wcount", {56'd0, word_count}, 64'd0);
    check_eq("t6_wrap_data", out_data, 64'h06050403020100FF);
    check_eq("t6_wrap_fill", {61'd0, fill_level}, 64'd0);
    for (int b = 0; b < 8; b++) send_byte(8'(8'h50 + b), 1'b0);
    in_valid = 1'b0;
    tick();
    check_eq("t6_257_wcount", {56'd0, word_count}, 64'd1);
    check_eq("t6_257_data", out_data, 64'h5756555453525150);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
